// File: rtl/daisy_rst_seq_pkg.sv
// Shared types and default sizing for the DAISY reset sequencer.
package daisy_rst_pkg;

    typedef enum logic [1:0] {
        CH_RST  = 2'd0,
        CH_WAIT = 2'd1,
        CH_RUN  = 2'd2,
        CH_SRST = 2'd3
    } ch_state_e;

    localparam int NCH_DEF       = 4;
    localparam int DIV_W_DEF     = 4;
    localparam int DLY_W_DEF     = 8;
    localparam int SRST_HOLD_DEF = 16;

    // Width able to hold SRST_HOLD-1, never narrower than one bit.
    function automatic int hold_width(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/daisy_rst_seq_if.sv
// Configuration, soft-reset handshake and per-channel reset/enable bundle.
interface daisy_rst_seq_if
    import daisy_rst_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int DLY_W = DLY_W_DEF
);
    logic [NCH*DIV_W-1:0] cfg_div;
    logic [NCH*DLY_W-1:0] cfg_dly;
    logic [NCH-1:0]       srst_req;
    logic [NCH-1:0]       srst_ack;
    logic [NCH-1:0]       ch_rst_n;
    logic [NCH-1:0]       ch_ce;
    logic                 all_ready;

    modport master (
        output cfg_div, cfg_dly, srst_req,
        input  srst_ack, ch_rst_n, ch_ce, all_ready
    );

    modport slave (
        input  cfg_div, cfg_dly, srst_req,
        output srst_ack, ch_rst_n, ch_ce, all_ready
    );
endinterface

// File: rtl/daisy_rst_seq_ce_div.sv
// One clock-enable divider: ce pulses once every div+1 cycles, div shadowed per period.
module daisy_ce_div #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    output logic             ce
);
    logic             started;
    logic             load;
    logic [DIV_W-1:0] cnt, cnt_nx;
    logic [DIV_W-1:0] div_q, div_nx;

    // The first edge out of reset behaves like the edge after a ce cycle.
    always_comb begin
        load   = !started || ce;
        cnt_nx = load ? '0 : cnt + 1'b1;
        div_nx = load ? div : div_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started <= 1'b0;
            cnt     <= '0;
            div_q   <= '0;
            ce      <= 1'b0;
        end else begin
            started <= 1'b1;
            cnt     <= cnt_nx;
            div_q   <= div_nx;
            ce      <= (cnt_nx == div_nx);
        end
    end
endmodule

// File: rtl/daisy_rst_seq.sv
// Daisy-chained per-channel reset release with soft-reset handshake and ce dividers.
module daisy_rst_seq
    import daisy_rst_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int DIV_W     = DIV_W_DEF,
    parameter int DLY_W     = DLY_W_DEF,
    parameter int SRST_HOLD = SRST_HOLD_DEF
) (
    input  logic           clk,
    input  logic           rest,
    daisy_rst_seq_if.slave bus
);
    localparam int HOLD_W = hold_width(SRST_HOLD);

    logic [NCH-1:0] in_run;
    logic [NCH-1:0] up_ok;
    logic [NCH-1:0] ack_vec;
    logic [NCH-1:0] rst_n_vec;
    logic [NCH-1:0] ce_vec;

    // up_ok[i]: every channel upstream of i is in RUN; losing it forces i back to RST.
    assign up_ok[0] = 1'b1;
    generate
        for (genvar i = 1; i < NCH; i++) begin : g_up
            assign up_ok[i] = up_ok[i-1] & in_run[i-1];
        end
    endgenerate

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            ch_state_e         st, st_nx;
            logic [DLY_W-1:0]  dly_cnt, dly_nx;
            logic [HOLD_W-1:0] hold_cnt, hold_nx;
            logic              ack_q, ack_nx;
            logic              rst_n_q;
            logic [DLY_W-1:0]  dly_cfg;
            logic              req;

            assign dly_cfg = bus.cfg_dly[i*DLY_W +: DLY_W];
            assign req     = bus.srst_req[i];

            always_comb begin
                st_nx   = st;
                dly_nx  = dly_cnt;
                hold_nx = hold_cnt;
                ack_nx  = 1'b0;
                if (!up_ok[i]) begin
                    st_nx   = CH_RST;
                    dly_nx  = '0;
                    hold_nx = '0;
                end else begin
                    case (st)
                        CH_RST: begin
                            st_nx  = CH_WAIT;
                            dly_nx = dly_cfg;
                        end
                        CH_WAIT: begin
                            if (dly_cnt == '0) st_nx = CH_RUN;
                            else               dly_nx = dly_cnt - 1'b1;
                        end
                        CH_RUN: begin
                            if (req) begin
                                st_nx   = CH_SRST;
                                hold_nx = HOLD_W'(SRST_HOLD - 1);
                            end
                        end
                        CH_SRST: begin
                            // The hold always runs to completion; only then is req honoured.
                            if (hold_cnt != '0) begin
                                hold_nx = hold_cnt - 1'b1;
                            end else if (req) begin
                                ack_nx = 1'b1;
                            end else begin
                                st_nx  = CH_WAIT;
                                dly_nx = dly_cfg;
                            end
                        end
                        default: st_nx = CH_RST;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rest) begin
                if (rest) begin
                    st       <= CH_RST;
                    dly_cnt  <= '0;
                    hold_cnt <= '0;
                    ack_q    <= 1'b0;
                    rst_n_q  <= 1'b0;
                end else begin
                    st       <= st_nx;
                    dly_cnt  <= dly_nx;
                    hold_cnt <= hold_nx;
                    ack_q    <= ack_nx;
                    rst_n_q  <= (st_nx == CH_RUN);
                end
            end

            assign in_run[i]    = (st == CH_RUN);
            assign ack_vec[i]   = ack_q;
            assign rst_n_vec[i] = rst_n_q;

            daisy_ce_div #(.DIV_W(DIV_W)) u_div (
                .clk (clk),
                .rst (rest),
                .div (bus.cfg_div[i*DIV_W +: DIV_W]),
                .ce  (ce_vec[i])
            );
        end
    endgenerate

    assign bus.srst_ack  = ack_vec;
    assign bus.ch_rst_n  = rst_n_vec;
    assign bus.ch_ce     = ce_vec;
    assign bus.all_ready = &in_run;

endmodule

// File: tb/tb_daisy_rst_seq.sv
// Bench for daisy_rst_seq: schedule-based reference model plus directed scenarios.
module tb_daisy_rst_seq;
    localparam int NCH   = 4;
    localparam int DIV_W = 4;
    localparam int DLY_W = 8;
    localparam int HOLD  = 16;

    logic clk = 1'b0;
    logic rest;
    int   errors = 0;
    int   checks = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    daisy_rst_seq_if #(.NCH(NCH), .DIV_W(DIV_W), .DLY_W(DLY_W)) bus ();

    daisy_rst_seq #(.NCH(NCH), .DIV_W(DIV_W), .DLY_W(DLY_W), .SRST_HOLD(HOLD)) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

    // Reference model: each channel is described by release times and soft-reset
    // start times measured in edges since reset exit.
    int n = 0;
    bit up[NCH], upo[NCH], pend[NCH], ack_m[NCH], ce_m[NCH];
    int rel[NCH], s0[NCH], ce_next[NCH];

    always @(posedge clk or posedge rest) begin
        if (rest) begin
            n = 0;
            for (int i = 0; i < NCH; i++) begin
                up[i] = 0; pend[i] = 0; ack_m[i] = 0; ce_m[i] = 0;
                rel[i] = 0; s0[i] = -1; ce_next[i] = 0;
            end
        end else begin
            upo = up;
            for (int i = 0; i < NCH; i++) begin
                bit fwd;
                int dly;
                fwd = 1;
                for (int k = 0; k < i; k++) if (!upo[k]) fwd = 0;
                dly = int'(bus.cfg_dly[i*DLY_W +: DLY_W]);
                if (!fwd) begin
                    up[i] = 0; pend[i] = 0; s0[i] = -1; ack_m[i] = 0;
                end else if (upo[i]) begin
                    if (bus.srst_req[i]) begin up[i] = 0; s0[i] = n; end
                end else if (s0[i] >= 0) begin
                    if (n - s0[i] >= HOLD) begin
                        if (bus.srst_req[i]) ack_m[i] = 1;
                        else begin ack_m[i] = 0; s0[i] = -1; pend[i] = 1; rel[i] = n + dly + 1; end
                    end
                end else if (pend[i]) begin
                    if (n == rel[i]) begin up[i] = 1; pend[i] = 0; end
                end else begin
                    pend[i] = 1; rel[i] = n + dly + 1;
                end
                if (n == 0 || n == ce_next[i] + 1)
                    ce_next[i] = n + int'(bus.cfg_div[i*DIV_W +: DIV_W]);
                ce_m[i] = (n == ce_next[i]);
            end
            n++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NCH-1:0] e_rst, e_ce, e_ack;
            logic           e_rdy;
            e_rdy = 1'b1;
            for (int i = 0; i < NCH; i++) begin
                e_rst[i] = up[i]; e_ce[i] = ce_m[i]; e_ack[i] = ack_m[i];
                e_rdy = e_rdy & up[i];
            end
            checks += 4;
            if (bus.ch_rst_n !== e_rst) begin
                errors++; $display("FAIL cyc_rst_n t=%0t got %b expected %b", $time, bus.ch_rst_n, e_rst);
            end
            if (bus.ch_ce !== e_ce) begin
                errors++; $display("FAIL cyc_ce t=%0t got %b expected %b", $time, bus.ch_ce, e_ce);
            end
            if (bus.srst_ack !== e_ack) begin
                errors++; $display("FAIL cyc_ack t=%0t got %b expected %b", $time, bus.srst_ack, e_ack);
            end
            if (bus.all_ready !== e_rdy) begin
                errors++; $display("FAIL cyc_ready t=%0t got %b expected %b", $time, bus.all_ready, e_rdy);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Counts edges until ch_ce[1] is seen high, starting from an existing count.
    task automatic gap_to_ce1(input int start, output int gap);
        gap = start;
        do begin
            wait_edges(1);
            gap++;
        end while (!bus.ch_ce[1] && gap < 20);
    endtask

    // Releases rest and checks the nominal release edges 4, 9, 14, 19 for cfg_dly=3.
    task automatic nominal_release();
        @(negedge clk) rest = 1'b0;
        wait_edges(4);  chk("nom_e3_rst_n",  32'(bus.ch_rst_n), 32'h0);
        wait_edges(1);  chk("nom_e4_rst_n",  32'(bus.ch_rst_n), 32'h1);
                        chk("nom_e4_ce",     32'(bus.ch_ce),    32'hF);
        wait_edges(5);  chk("nom_e9_rst_n",  32'(bus.ch_rst_n), 32'h3);
        wait_edges(5);  chk("nom_e14_rst_n", 32'(bus.ch_rst_n), 32'h7);
        wait_edges(4);  chk("nom_e18_ready", 32'(bus.all_ready), 32'h0);
        wait_edges(1);  chk("nom_e19_rst_n", 32'(bus.ch_rst_n), 32'hF);
                        chk("nom_e19_ready", 32'(bus.all_ready), 32'h1);
    endtask

    initial begin
        int gap;
        rest         = 1'b1;
        bus.cfg_dly  = {NCH{8'd3}};
        bus.cfg_div  = '0;
        bus.srst_req = '0;
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_rst_n", 32'(bus.ch_rst_n), 32'h0);
        chk("reset_ce",    32'(bus.ch_ce),    32'h0);
        chk("reset_ack",   32'(bus.srst_ack), 32'h0);
        repeat (2) @(negedge clk);

        nominal_release();

        // Divider: period 3, then a mid-period write of 4 gives one more 3 then 5.
        bus.cfg_div[1*DIV_W +: DIV_W] = 4'd2;
        gap_to_ce1(0, gap);
        gap_to_ce1(0, gap);  chk("div2_gap", 32'(gap), 32'd3);
        wait_edges(1);
        bus.cfg_div[1*DIV_W +: DIV_W] = 4'd4;
        gap_to_ce1(1, gap);  chk("div_change_gap", 32'(gap), 32'd3);
        gap_to_ce1(0, gap);  chk("div4_gap", 32'(gap), 32'd5);

        // Cascaded soft reset from channel 1.
        bus.srst_req[1] = 1'b1;
        wait_edges(1);  chk("c1_e0_rst_n", 32'(bus.ch_rst_n), 32'hD);
                        chk("c1_e0_ready", 32'(bus.all_ready), 32'h0);
        wait_edges(1);  chk("c1_e1_rst_n", 32'(bus.ch_rst_n), 32'h1);
        wait_edges(14); chk("c1_e15_ack",  32'(bus.srst_ack), 32'h0);
        wait_edges(1);  chk("c1_e16_ack",  32'(bus.srst_ack), 32'h2);
        bus.srst_req[1] = 1'b0;
        wait_edges(1);  chk("c1_e17_ack",  32'(bus.srst_ack), 32'h0);
        wait_edges(3);  chk("c1_e20_rst_n", 32'(bus.ch_rst_n), 32'h1);
        wait_edges(1);  chk("c1_e21_rst_n", 32'(bus.ch_rst_n), 32'h3);
        wait_edges(5);  chk("c1_e26_rst_n", 32'(bus.ch_rst_n), 32'h7);
        wait_edges(5);  chk("c1_e31_rst_n", 32'(bus.ch_rst_n), 32'hF);

        // Last channel alone, request dropped early.
        bus.srst_req[3] = 1'b1;
        wait_edges(1);  chk("c3_e0_rst_n", 32'(bus.ch_rst_n), 32'h7);
        wait_edges(1);  chk("c3_e1_rst_n", 32'(bus.ch_rst_n), 32'h7);
        bus.srst_req[3] = 1'b0;
        wait_edges(14); chk("c3_e15_rst_n", 32'(bus.ch_rst_n), 32'h7);
        wait_edges(5);  chk("c3_e20_rst_n", 32'(bus.ch_rst_n), 32'hF);

        // Short request on channel 0: full hold, no ack, whole chain restarts.
        bus.srst_req[0] = 1'b1;
        wait_edges(1);  chk("c0_e0_rst_n", 32'(bus.ch_rst_n), 32'hE);
        wait_edges(1);  chk("c0_e1_rst_n", 32'(bus.ch_rst_n), 32'h0);
        wait_edges(1);
        bus.srst_req[0] = 1'b0;
        wait_edges(14); chk("c0_e16_ack",  32'(bus.srst_ack), 32'h0);
        wait_edges(3);  chk("c0_e19_rst_n", 32'(bus.ch_rst_n), 32'h0);
        wait_edges(1);  chk("c0_e20_rst_n", 32'(bus.ch_rst_n), 32'h1);
        wait_edges(14); chk("c0_e34_rst_n", 32'(bus.ch_rst_n), 32'h7);
        wait_edges(1);  chk("c0_e35_rst_n", 32'(bus.ch_rst_n), 32'hF);

        // Asynchronous reset while channel 2 is in WAIT, then a clean restart.
        rest = 1'b1;
        repeat (2) @(negedge clk);
        bus.cfg_div = '0;
        @(negedge clk) rest = 1'b0;
        wait_edges(12); chk("mid_pre_rst_n", 32'(bus.ch_rst_n), 32'h3);
        rest = 1'b1;
        #1;
        chk("mid_async_rst_n", 32'(bus.ch_rst_n),  32'h0);
        chk("mid_async_ce",    32'(bus.ch_ce),     32'h0);
        chk("mid_async_ack",   32'(bus.srst_ack),  32'h0);
        chk("mid_async_ready", 32'(bus.all_ready), 32'h0);
        repeat (3) @(negedge clk);
        nominal_release();
        wait_edges(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/daisy_rst_seq.md
# daisy_rst_seq

Parametrised reset sequencer and clock-enable generator for the DAISY subsystem. It replaces fixed two-domain clock/reset generation with NCH channels. Channels leave reset one after another in a daisy chain, each after its own programmable delay. Each channel also gets a programmable clock-enable divider and a 4-phase soft-reset handshake that cascades down the chain. It sits at the top of the design, directly after the clock source, and drives per-channel reset and enable into the bus and core blocks.

## Interface
- NCH, 4, number of channels (1..16)
- DIV_W, 4, width of each clock-enable divide field
- DLY_W, 8, width of each release-delay field
- SRST_HOLD, 16, minimum soft-reset assertion in cycles (≥1)

- clk  in  1  sole clock
- rest  in  1  asynchronous, active-high reset
- cfg_div  in  NCH*DIV_W  per-channel divide value; field i is bits [i*DIV_W +: DIV_W]
- cfg_dly  in  NCH*DLY_W  per-channel release delay; field i is bits [i*DLY_W +: DLY_W]
- srst_req  in  NCH  per-channel soft-reset request (level)
- srst_ack  out  NCH  soft-reset acknowledge
- ch_rst_n  out  NCH  per-channel active-low reset, registered
- ch_ce  out  NCH  per-channel clock-enable pulse, registered
- all_ready  out  1  high when every channel is in RUN

## Operation
- Each channel has four states: RST, WAIT, RUN, SRST.
- RST → WAIT:
  - Channel 0 moves on the first edge with rest low.
  - Channel i>0 moves on the edge after channel i-1 is in RUN.
- Entry to WAIT loads a delay counter with cfg_dly[i].
- WAIT → RUN:
  - Each WAIT cycle decrements the counter.
  - When the counter reads 0, the channel moves to RUN on the next edge.
  - WAIT therefore lasts cfg_dly+1 cycles.
- RUN → SRST when srst_req[i] is sampled high.
  - The channel stays in SRST for at least SRST_HOLD cycles.
  - Once the hold expires, srst_ack[i] goes high and stays high while srst_req[i] is high.
  - When srst_req[i] is sampled low after the hold, the channel goes to WAIT and srst_ack drops.
- Early request drop: if srst_req falls before the hold expires, the hold still completes. srst_ack never asserts, and the channel then goes to WAIT.
- Cascade: any channel j>i that is not in RST is forced to RST on the edge after channel i leaves RUN. Its srst_ack clears and its counters reload on re-entry. It then re-sequences normally.
- srst_req is ignored in RST and WAIT.
  - A request still high when the channel reaches RUN starts a new SRST.
- ch_rst_n[i] is a flop, set when the next state is RUN and cleared otherwise.
- all_ready is the AND of all channels being in RUN (decoded from registers).
- Clock-enable divider, per channel:
  - An up-counter counts 0..div_q.
  - ch_ce is high on the cycle the counter equals div_q, and the counter then wraps to 0.
  - div_q is a shadow of cfg_div[i], loaded at reset exit and on every ce cycle.
  - div=0 gives ce continuously high.
  - The divider runs independently of channel state.

## Timing
- Reset values (asynchronous on rest): ch_rst_n=0, ch_ce=0, srst_ack=0, all_ready=0, all states RST, all counters 0.
- Edge numbering: edge 0 is the first rising edge with rest low.
  - Channel i releases (ch_rst_n rises) after edge Σ_{k≤i}(cfg_dly[k]+2) − 1.
- Soft reset: ch_rst_n[i] falls after the edge that samples srst_req high. srst_ack rises SRST_HOLD edges later.
- Downstream channels drop ch_rst_n one edge after channel i drops.
- cfg_dly is sampled only on WAIT entry. cfg_div changes take effect after the next ce pulse.
- rest asserted at any point, including mid-WAIT or mid-SRST, clears everything immediately. The full sequence restarts from RST.
- Simultaneous requests on channels i<j: channel i wins. Channel j is forced to RST, which is the cascade rule.

## Structure
- Package daisy_rst_pkg holds:
  - the enum ch_state_e {CH_RST, CH_WAIT, CH_RUN, CH_SRST};
  - the default parameter constants.
- Sub-module daisy_ce_div holds one divider (counter, shadow register, ce flop) and is instantiated NCH times by generate.
- The top level holds the per-channel FSMs, delay/hold counters and cascade logic.

## Test plan
- Nominal release: NCH=4, all cfg_dly=3, cfg_div=0, release rest → ch_rst_n[0..3] rise after edges 4, 9, 14, 19; all_ready after edge 19; ch_ce all high from edge 0.
- Divider change: cfg_div[1]=2 → ch_ce[1] pulses every 3 cycles. Write 4 mid-period → one more 3-cycle period, then every 5 cycles.
- Cascaded soft reset: steady state, srst_req[1]=1 → ch_rst_n[1] low next edge, [2],[3] low one edge later, all_ready low. srst_ack[1] after 16 cycles. Drop req → ch1 releases after 4 more edges, then ch2 and ch3 re-sequence.
- Last-channel soft reset: srst_req[3] only → ch_rst_n[0..2] stay high; ch3 cycles alone.
- Short request: srst_req[0] high for 3 cycles → full 16-cycle hold, srst_ack[0] never rises, chain re-sequences.
- Mid-operation reset: assert rest while ch2 is in WAIT → all outputs 0 immediately, with no clk edge needed. Deassert → timing identical to the nominal-release scenario.
